alu_8bit: RTL and testbench

ALU_8BIT -- requirements
Module: alu_8bit

---
 rtl/alu_8bit.sv | 124 ++++++++++++
 tb/tb_alu_8bit.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_8bit.sv
// 8-bit registered ALU: 16 operations selected by sel, result and carry captured every rising edge.
// Optional zero/signed-overflow flag outputs zf/vf are built when ALU8_FLAGS_EN is defined.
module alu_8bit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  input  logic [3:0] sel,
`ifdef ALU8_FLAGS_EN
  output logic       zf,
  output logic       vf,
`endif
  output logic [7:0] s,
  output logic       cout
);

`ifdef ALU8_FLAGS_EN
  // Signed overflow: operands share a sign that the result does not.
  function automatic logic f_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
    return (a_msb == b_msb) && (r_msb != a_msb);
  endfunction
`endif

  logic [7:0] w_addend;
  logic [8:0] w_sum;
  logic [7:0] w_res;
  logic       w_cout;
  logic [7:0] r_s;
  logic       r_cout;

  // Second adder operand for the four arithmetic codes (sel[1:0] picks 0, B, ~B or all-ones)
  always_comb begin
    w_addend = 8'h00;
    case (sel[1:0])
      2'b00:   w_addend = 8'h00;
      2'b01:   w_addend = b;
      2'b10:   w_addend = ~b;
      2'b11:   w_addend = 8'hFF;
      default: w_addend = 8'h00;
    endcase
  end

  assign w_sum = {1'b0, a} + {1'b0, w_addend} + {8'h00, cin};

  // Next result/carry decode for all 16 operation codes
  always_comb begin
    w_res  = 8'h00;
    w_cout = 1'b0;
    case (sel)
      4'b0000, 4'b0001, 4'b0010, 4'b0011: begin
        w_res  = w_sum[7:0];
        w_cout = w_sum[8];
      end
      4'b0100: w_res = a & b;
      4'b0101: w_res = a | b;
      4'b0110: w_res = a ^ b;
      4'b0111: w_res = ~a;
      4'b1000: w_res = ~(a | b);
      4'b1001: w_res = ~(a ^ b);
      4'b1010: w_res = b;
      4'b1011: w_res = 8'h00;
      4'b1100: begin
        w_res  = {a[6:0], 1'b0};
        w_cout = a[7];
      end
      4'b1101: begin
        w_res  = {a[6:0], cin};
        w_cout = a[7];
      end
      4'b1110: begin
        w_res  = {cin, a[7:1]};
        w_cout = a[0];
      end
      4'b1111: begin
        w_res  = {a[7], a[7:1]};
        w_cout = a[0];
      end
      default: begin
        w_res  = 8'h00;
        w_cout = 1'b0;
      end
    endcase
  end

  // Result and carry registers; reset clears them immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s    <= 8'h00;
      r_cout <= 1'b0;
    end else begin
      r_s    <= w_res;
      r_cout <= w_cout;
    end
  end

  assign s    = r_s;
  assign cout = r_cout;

`ifdef ALU8_FLAGS_EN
  logic w_zf;
  logic w_vf;
  logic r_zf;
  logic r_vf;

  assign w_zf = (w_res == 8'h00);
  assign w_vf = (sel[3:2] == 2'b00) ? f_ovf(a[7], w_addend[7], w_sum[7]) : 1'b0;

  // Flag registers, captured alongside the result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_zf <= 1'b0;
      r_vf <= 1'b0;
    end else begin
      r_zf <= w_zf;
      r_vf <= w_vf;
    end
  end

  assign zf = r_zf;
  assign vf = r_vf;
`endif

endmodule

// File: tb/tb_alu_8bit.sv
// Self-checking bench for alu_8bit: vector table, reset/hold sequences and random vectors
// scored through an expected-result queue. Flag checks compile in with ALU8_FLAGS_EN.
`timescale 1ns/1ps
module tb_alu_8bit;

  typedef struct {
    logic [3:0] sel;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] s;
    logic       c;
    logic       z;
    logic       v;
  } vec_t;

  typedef struct {
    logic [7:0] s;
    logic       c;
    logic       z;
    logic       v;
    int         id;
  } exp_t;

  localparam int NV = 24;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic [3:0] sel;
  logic [7:0] s;
  logic       cout;
`ifdef ALU8_FLAGS_EN
  logic       zf;
  logic       vf;
`endif

  int   total = 0;
  int   bad   = 0;
  vec_t tab[NV];
  exp_t sb[$];

  alu_8bit dut (
    .clk  (clk),
    .rst_n(rst_n),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .sel  (sel),
`ifdef ALU8_FLAGS_EN
    .zf   (zf),
    .vf   (vf),
`endif
    .s    (s),
    .cout (cout)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string nm, input int id, input logic [7:0] act, input logic [7:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s id=%0d actual=%h required=%h", nm, id, act, req);
    end
  endtask

  // Independent reference: integer arithmetic, signed range test for overflow.
  function automatic exp_t model(input logic [3:0] op, input logic [7:0] x, input logic [7:0] y,
                                 input logic ci);
    exp_t e;
    int   u;
    int   sv;
    int   opnd;
    e.s = 8'h00; e.c = 1'b0; e.v = 1'b0; e.id = 0;
    if (op < 4'd4) begin
      opnd = (op == 4'd0) ? 0 : (op == 4'd1) ? int'(y) : (op == 4'd2) ? 255 - int'(y) : 255;
      u    = int'(x) + opnd + int'(ci);
      e.s  = u[7:0];
      e.c  = (u > 255);
      sv   = int'($signed(x)) + ((opnd > 127) ? opnd - 256 : opnd) + int'(ci);
      e.v  = (sv > 127) || (sv < -128);
    end else begin
      case (op)
        4'd4:  e.s = x & y;
        4'd5:  e.s = x | y;
        4'd6:  e.s = x ^ y;
        4'd7:  e.s = ~x;
        4'd8:  e.s = ~(x | y);
        4'd9:  e.s = ~(x ^ y);
        4'd10: e.s = y;
        4'd11: e.s = 8'h00;
        4'd12: begin e.s = x << 1;                 e.c = x[7]; end
        4'd13: begin e.s = (x << 1) | {7'd0, ci};  e.c = x[7]; end
        4'd14: begin e.s = (x >> 1) | {ci, 7'd0};  e.c = x[0]; end
        default: begin e.s = (x >> 1) | (x & 8'h80); e.c = x[0]; end
      endcase
    end
    e.z = (e.s == 8'h00);
    return e;
  endfunction

  task automatic drive_push(input logic [3:0] op, input logic [7:0] x, input logic [7:0] y,
                            input logic ci, input exp_t e);
    sel = op; a = x; b = y; cin = ci;
    sb.push_back(e);
  endtask

  task automatic pop_check(input string nm);
    exp_t e;
    if (sb.size() == 0) begin
      total++; bad++;
      $display("FAIL %s scoreboard empty actual=%h required=entry", nm, s);
    end else begin
      e = sb.pop_front();
      cmp({nm, "_s"}, e.id, s, e.s);
      cmp({nm, "_cout"}, e.id, {7'd0, cout}, {7'd0, e.c});
`ifdef ALU8_FLAGS_EN
      cmp({nm, "_zf"}, e.id, {7'd0, zf}, {7'd0, e.z});
      cmp({nm, "_vf"}, e.id, {7'd0, vf}, {7'd0, e.v});
`endif
    end
  endtask

  initial begin
    exp_t e;
    // sel, a, b, cin, s, cout, zf, vf
    tab[0]  = '{4'b0001, 8'h73, 8'hAF, 1'b0, 8'h22, 1'b1, 1'b0, 1'b0};
    tab[1]  = '{4'b0100, 8'h32, 8'hB0, 1'b1, 8'h30, 1'b0, 1'b0, 1'b0};
    tab[2]  = '{4'b0010, 8'h0A, 8'h0F, 1'b1, 8'hFB, 1'b0, 1'b0, 1'b0};
    tab[3]  = '{4'b1101, 8'h8E, 8'h00, 1'b1, 8'h1D, 1'b1, 1'b0, 1'b0};
    tab[4]  = '{4'b1110, 8'h7F, 8'h00, 1'b0, 8'h3F, 1'b1, 1'b0, 1'b0};
    tab[5]  = '{4'b1111, 8'hAA, 8'h00, 1'b1, 8'hD5, 1'b0, 1'b0, 1'b0};
    tab[6]  = '{4'b0001, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b0, 1'b1};
    tab[7]  = '{4'b0001, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
    tab[8]  = '{4'b0000, 8'hFF, 8'h33, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0};
    tab[9]  = '{4'b0000, 8'h7F, 8'h33, 1'b1, 8'h80, 1'b0, 1'b0, 1'b1};
    tab[10] = '{4'b0010, 8'h50, 8'h20, 1'b1, 8'h30, 1'b1, 1'b0, 1'b0};
    tab[11] = '{4'b0010, 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b0, 1'b1};
    tab[12] = '{4'b0011, 8'h00, 8'h12, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0};
    tab[13] = '{4'b0011, 8'h05, 8'h12, 1'b1, 8'h05, 1'b1, 1'b0, 1'b0};
    tab[14] = '{4'b0011, 8'h80, 8'h00, 1'b0, 8'h7F, 1'b1, 1'b0, 1'b1};
    tab[15] = '{4'b0101, 8'h0F, 8'hF0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0};
    tab[16] = '{4'b0110, 8'hFF, 8'h0F, 1'b0, 8'hF0, 1'b0, 1'b0, 1'b0};
    tab[17] = '{4'b0111, 8'h3C, 8'hAA, 1'b1, 8'hC3, 1'b0, 1'b0, 1'b0};
    tab[18] = '{4'b1000, 8'h0F, 8'hF0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
    tab[19] = '{4'b1001, 8'hA5, 8'hA5, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0};
    tab[20] = '{4'b1010, 8'h11, 8'h5A, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0};
    tab[21] = '{4'b1011, 8'hFF, 8'hFF, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0};
    tab[22] = '{4'b1100, 8'h81, 8'h00, 1'b1, 8'h02, 1'b1, 1'b0, 1'b0};
    tab[23] = '{4'b1111, 8'h81, 8'h00, 1'b0, 8'hC0, 1'b1, 1'b0, 1'b0};

    // Reset holds outputs at zero even while clocks run
    rst_n = 1'b0; sel = 4'b0001; a = 8'h01; b = 8'h01; cin = 1'b0;
    #1;
    cmp("rst_s", 0, s, 8'h00);
    cmp("rst_cout", 0, {7'd0, cout}, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    cmp("rst_hold_s", 0, s, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    e = '{8'h02, 1'b0, 1'b0, 1'b0, 100};
    drive_push(4'b0001, 8'h01, 8'h01, 1'b0, e);
    @(posedge clk); #1;
    pop_check("first_capture");

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      e = '{tab[i].s, tab[i].c, tab[i].z, tab[i].v, i};
      drive_push(tab[i].sel, tab[i].a, tab[i].b, tab[i].cin, e);
      @(posedge clk); #1;
      pop_check("vec");
    end

    // Inputs changing between edges must not reach s until the next edge
    @(negedge clk);
    e = '{8'h30, 1'b0, 1'b0, 1'b0, 200};
    drive_push(4'b0001, 8'h10, 8'h20, 1'b0, e);
    @(posedge clk); #1;
    pop_check("hold_a");
    #2;
    e = model(4'b0001, 8'hF0, 8'h20, 1'b1); e.id = 201;
    drive_push(4'b0001, 8'hF0, 8'h20, 1'b1, e);
    #1;
    cmp("hold_mid_s", 201, s, 8'h30);
    @(posedge clk); #1;
    pop_check("hold_b");

    // Mid-cycle reset discards the loaded nonzero result immediately
    @(negedge clk);
    e = '{8'hAB, 1'b0, 1'b0, 1'b0, 300};
    drive_push(4'b1010, 8'h00, 8'hAB, 1'b0, e);
    @(posedge clk); #1;
    pop_check("pre_rst");
    #2;
    rst_n = 1'b0;
    #1;
    cmp("async_rst_s", 300, s, 8'h00);
    cmp("async_rst_cout", 300, {7'd0, cout}, 8'h00);
    @(posedge clk); #1;
    cmp("rst_edge_s", 300, s, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    e = '{8'hCC, 1'b0, 1'b0, 1'b0, 301};
    drive_push(4'b0110, 8'hF0, 8'h3C, 1'b1, e);
    @(posedge clk); #1;
    pop_check("post_rst");

    for (int i = 0; i < 48; i++) begin
      logic [3:0] r_op;
      logic [7:0] r_a;
      logic [7:0] r_b;
      logic       r_c;
      @(negedge clk);
      r_op = 4'($urandom_range(0, 15));
      r_a  = 8'($urandom);
      r_b  = 8'($urandom);
      r_c  = 1'($urandom);
      e = model(r_op, r_a, r_b, r_c); e.id = 400 + i;
      drive_push(r_op, r_a, r_b, r_c, e);
      @(posedge clk); #1;
      pop_check("rand");
    end

    if (sb.size() != 0) begin
      total++; bad++;
      $display("FAIL sb_drain actual=%0d required=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
